// File: rtl/hazard_unit_if.sv
// Hazard-unit bundle: ID/EX/MEM hazard inputs toward the unit, stall/flush controls and counters back.
// The slave side is the hazard unit; the master side is the pipeline that drives it.
interface hazard_unit_if #(
  parameter int CNT_W = 32
);
  logic [4:0]       ID_Rs;
  logic [4:0]       ID_Rt;
  logic             ID_UseRt;
  logic             ID_Branch;
  logic [1:0]       ID_PCSrc;
  logic             ID_Taken;
  logic             ID_MulDiv;
  logic             ID_ReadHiLo;
  logic             EX_MemRead;
  logic             EX_RegWrite;
  logic [4:0]       EX_WriteReg;
  logic             MEM_MemRead;
  logic [4:0]       MEM_WriteReg;
  logic             Ext_Stall;
  logic             PC_Write;
  logic             IF_ID_Write;
  logic             IF_ID_Flush;
  logic             ID_EX_Write;
  logic             ID_EX_Flush;
  logic             MD_Busy;
  logic [CNT_W-1:0] Stall_Count;
  logic [CNT_W-1:0] Flush_Count;

  modport slave (
    input  ID_Rs, ID_Rt, ID_UseRt, ID_Branch, ID_PCSrc, ID_Taken, ID_MulDiv, ID_ReadHiLo,
    input  EX_MemRead, EX_RegWrite, EX_WriteReg, MEM_MemRead, MEM_WriteReg, Ext_Stall,
    output PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Write, ID_EX_Flush,
    output MD_Busy, Stall_Count, Flush_Count
  );

  modport master (
    output ID_Rs, ID_Rt, ID_UseRt, ID_Branch, ID_PCSrc, ID_Taken, ID_MulDiv, ID_ReadHiLo,
    output EX_MemRead, EX_RegWrite, EX_WriteReg, MEM_MemRead, MEM_WriteReg, Ext_Stall,
    input  PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Write, ID_EX_Flush,
    input  MD_Busy, Stall_Count, Flush_Count
  );
endinterface

// File: rtl/hazard_unit.sv
// Pipeline hazard controller: combinational load-use/control-operand stalls, taken-transfer flush,
// mul/div busy FSM, saturating stall/flush counters. Stall controls are same-cycle; Ext_Stall freezes all.
module hazard_unit #(
  parameter int MD_LATENCY = 4,
  parameter int CNT_W      = 32
) (
  input logic          clk,
  input logic          reset,
  hazard_unit_if.slave hif
);
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } md_state_t;

  localparam logic [3:0] MD_LAT = 4'(MD_LATENCY);

  md_state_t        r_state;
  md_state_t        w_state_nxt;
  logic [3:0]       r_md_cnt;
  logic [3:0]       w_md_cnt_nxt;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  logic w_ctl, w_ex_src, w_ex_ctl, w_mem_ctl;
  logic w_h1, w_h2, w_h3, w_h4, w_haz, w_issue, w_busy;
  logic w_pc_write, w_ifid_write, w_ifid_flush, w_idex_write, w_idex_flush;
  logic w_unused;

  // PCSrc[0] only distinguishes j from branch targets; it plays no part in hazards.
  assign w_unused = hif.ID_PCSrc[0];

  assign w_busy = (r_state == ST_BUSY);
  assign w_ctl  = hif.ID_Branch | hif.ID_PCSrc[1];

  assign w_ex_src  = (hif.EX_WriteReg != 5'd0) &&
                     ((hif.ID_Rs == hif.EX_WriteReg) ||
                      (hif.ID_UseRt && (hif.ID_Rt == hif.EX_WriteReg)));
  // A jr only reads rs as its control operand; a branch compares rs and rt.
  assign w_ex_ctl  = (hif.EX_WriteReg != 5'd0) &&
                     ((hif.ID_Rs == hif.EX_WriteReg) ||
                      (hif.ID_Branch && (hif.ID_Rt == hif.EX_WriteReg)));
  assign w_mem_ctl = (hif.MEM_WriteReg != 5'd0) &&
                     ((hif.ID_Rs == hif.MEM_WriteReg) ||
                      (hif.ID_Branch && (hif.ID_Rt == hif.MEM_WriteReg)));

  assign w_h1  = hif.EX_MemRead & w_ex_src;
  assign w_h2  = w_ctl & hif.EX_RegWrite & w_ex_ctl;
  assign w_h3  = w_ctl & hif.MEM_MemRead & w_mem_ctl;
  assign w_h4  = w_busy & (hif.ID_MulDiv | hif.ID_ReadHiLo);
  assign w_haz = w_h1 | w_h2 | w_h3 | w_h4;

  assign w_issue = hif.ID_MulDiv & ~w_haz & ~hif.Ext_Stall & reset;

  always_comb begin
    w_pc_write   = 1'b1;
    w_ifid_write = 1'b1;
    w_ifid_flush = 1'b0;
    w_idex_write = 1'b1;
    w_idex_flush = 1'b0;
    if (!reset) begin
      w_pc_write = 1'b1;
    end else if (hif.Ext_Stall) begin
      w_pc_write   = 1'b0;
      w_ifid_write = 1'b0;
      w_idex_write = 1'b0;
    end else if (w_haz) begin
      w_pc_write   = 1'b0;
      w_ifid_write = 1'b0;
      w_idex_flush = 1'b1;
    end else if (hif.ID_Taken) begin
      w_ifid_flush = 1'b1;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_md_cnt_nxt = r_md_cnt;
    case (r_state)
      ST_IDLE: begin
        if (w_issue) begin
          w_state_nxt  = ST_BUSY;
          w_md_cnt_nxt = MD_LAT;
        end
      end
      ST_BUSY: begin
        // Keeps counting through Ext_Stall: the unit runs independently of the pipeline.
        w_md_cnt_nxt = r_md_cnt - 4'd1;
        if (r_md_cnt == 4'd1) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt  = ST_IDLE;
        w_md_cnt_nxt = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_md_cnt    <= 4'd0;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_md_cnt <= w_md_cnt_nxt;
      if (w_haz && !hif.Ext_Stall && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
      if (w_ifid_flush && (r_flush_cnt != '1)) begin
        r_flush_cnt <= r_flush_cnt + CNT_W'(1);
      end
    end
  end

  assign hif.PC_Write    = w_pc_write;
  assign hif.IF_ID_Write = w_ifid_write;
  assign hif.IF_ID_Flush = w_ifid_flush;
  assign hif.ID_EX_Write = w_idex_write;
  assign hif.ID_EX_Flush = w_idex_flush;
  assign hif.MD_Busy     = w_busy;
  assign hif.Stall_Count = r_stall_cnt;
  assign hif.Flush_Count = r_flush_cnt;
endmodule

// File: tb/tb_hazard_unit.sv
// Bench for hazard_unit: directed vector table, hand-written multi-cycle sequences,
// and a random run against a cycle-level reference model.
module tb_hazard_unit;
  localparam int CW   = 4;
  localparam int LAT  = 4;
  localparam int CMAX = 15;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  hazard_unit_if #(.CNT_W(CW)) hif ();
  hazard_unit #(.MD_LATENCY(LAT), .CNT_W(CW)) dut (.clk(clk), .reset(reset), .hif(hif));

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Model state: remaining busy cycles of mul/div, and the two counters.
  int m_left  = 0;
  int m_stall = 0;
  int m_flush = 0;

  typedef struct {
    logic [4:0] rs;
    logic [4:0] rt;
    logic       use_rt;
    logic       br;
    logic [1:0] pc;
    logic       tk;
    logic       exmr;
    logic       exrw;
    logic [4:0] exwr;
    logic       memmr;
    logic [4:0] memwr;
    logic       ext;
    logic [4:0] exp;   // {PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Write, ID_EX_Flush}
  } vec_t;

  vec_t tbl [15];

  function automatic vec_t mk(input int rs, input int rt, input bit use_rt, input bit br, input int pc,
                              input bit tk, input bit exmr, input bit exrw, input int exwr,
                              input bit memmr, input int memwr, input bit ext, input logic [4:0] exp);
    vec_t v;
    v.rs = 5'(rs); v.rt = 5'(rt); v.use_rt = use_rt; v.br = br; v.pc = 2'(pc); v.tk = tk;
    v.exmr = exmr; v.exrw = exrw; v.exwr = 5'(exwr); v.memmr = memmr; v.memwr = 5'(memwr);
    v.ext = ext; v.exp = exp;
    return v;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int pack_out();
    logic [4:0] o;
    o = {hif.PC_Write, hif.IF_ID_Write, hif.IF_ID_Flush, hif.ID_EX_Write, hif.ID_EX_Flush};
    return int'(o);
  endfunction

  function automatic bit m_haz();
    bit ctl, h1, h2, h3, h4;
    int ex, mem;
    ex  = int'(hif.EX_WriteReg);
    mem = int'(hif.MEM_WriteReg);
    ctl = hif.ID_Branch || hif.ID_PCSrc[1];
    h1 = hif.EX_MemRead && ex != 0 &&
         (int'(hif.ID_Rs) == ex || (hif.ID_UseRt && int'(hif.ID_Rt) == ex));
    h2 = ctl && hif.EX_RegWrite && ex != 0 &&
         (int'(hif.ID_Rs) == ex || (hif.ID_Branch && int'(hif.ID_Rt) == ex));
    h3 = ctl && hif.MEM_MemRead && mem != 0 &&
         (int'(hif.ID_Rs) == mem || (hif.ID_Branch && int'(hif.ID_Rt) == mem));
    h4 = (m_left > 0) && (hif.ID_MulDiv || hif.ID_ReadHiLo);
    return h1 || h2 || h3 || h4;
  endfunction

  function automatic int m_out();
    if (!reset)         return 5'b11010;
    if (hif.Ext_Stall)  return 5'b00000;
    if (m_haz())        return 5'b00011;
    if (hif.ID_Taken)   return 5'b11110;
    return 5'b11010;
  endfunction

  task automatic clr();
    hif.ID_Rs = 0; hif.ID_Rt = 0; hif.ID_UseRt = 0; hif.ID_Branch = 0; hif.ID_PCSrc = 0;
    hif.ID_Taken = 0; hif.ID_MulDiv = 0; hif.ID_ReadHiLo = 0; hif.EX_MemRead = 0;
    hif.EX_RegWrite = 0; hif.EX_WriteReg = 0; hif.MEM_MemRead = 0; hif.MEM_WriteReg = 0;
    hif.Ext_Stall = 0;
  endtask

  task automatic apply(input vec_t v);
    clr();
    hif.ID_Rs = v.rs; hif.ID_Rt = v.rt; hif.ID_UseRt = v.use_rt; hif.ID_Branch = v.br;
    hif.ID_PCSrc = v.pc; hif.ID_Taken = v.tk; hif.EX_MemRead = v.exmr; hif.EX_RegWrite = v.exrw;
    hif.EX_WriteReg = v.exwr; hif.MEM_MemRead = v.memmr; hif.MEM_WriteReg = v.memwr;
    hif.Ext_Stall = v.ext;
  endtask

  task automatic load_use();
    clr();
    hif.EX_MemRead = 1; hif.EX_RegWrite = 1; hif.EX_WriteReg = 8; hif.ID_Rt = 8; hif.ID_UseRt = 1;
  endtask

  task automatic go();
    #2;
  endtask

  // Compare against the model, take the edge, advance the model, then return 1 time unit past the edge.
  task automatic tick();
    bit haz, iss;
    int o;
    chk("model_outs", pack_out(), m_out());
    chk("model_busy", int'(hif.MD_Busy), int'(m_left > 0));
    chk("model_stall_cnt", int'(hif.Stall_Count), m_stall);
    chk("model_flush_cnt", int'(hif.Flush_Count), m_flush);
    @(posedge clk);
    if (!reset) begin
      m_left = 0; m_stall = 0; m_flush = 0;
    end else begin
      haz = m_haz();
      o   = m_out();
      iss = hif.ID_MulDiv && !haz && !hif.Ext_Stall;
      if (m_left > 0) m_left--;
      else if (iss)   m_left = LAT;
      if (haz && !hif.Ext_Stall && m_stall < CMAX) m_stall++;
      if (((o >> 2) & 1) == 1 && m_flush < CMAX)    m_flush++;
    end
    #1;
  endtask

  task automatic do_reset();
    reset = 0; load_use(); hif.ID_MulDiv = 1;
    go();
    chk("reset_outs", pack_out(), 5'b11010);
    tick();
    reset = 1; clr();
    go();
    chk("reset_busy", int'(hif.MD_Busy), 0);
    chk("reset_stall_cnt", int'(hif.Stall_Count), 0);
    chk("reset_flush_cnt", int'(hif.Flush_Count), 0);
    tick();
  endtask

  initial begin
    tbl[0]  = mk( 1,  2, 1, 0, 0, 0, 0, 0,  0, 0, 0, 0, 5'b11010);
    tbl[1]  = mk( 3,  8, 1, 0, 0, 0, 1, 1,  8, 0, 0, 0, 5'b00011);
    tbl[2]  = mk( 3,  8, 0, 0, 0, 0, 1, 1,  8, 0, 0, 0, 5'b11010);
    tbl[3]  = mk( 0,  0, 1, 0, 0, 0, 1, 1,  0, 0, 0, 0, 5'b11010);
    tbl[4]  = mk( 5,  0, 0, 1, 0, 0, 0, 1,  5, 0, 0, 0, 5'b00011);
    tbl[5]  = mk(31,  0, 0, 0, 2, 0, 0, 1, 31, 0, 0, 0, 5'b00011);
    tbl[6]  = mk( 3, 31, 1, 0, 2, 0, 0, 1, 31, 0, 0, 0, 5'b11010);
    tbl[7]  = mk( 1,  7, 1, 1, 0, 0, 0, 0,  0, 1, 7, 0, 5'b00011);
    tbl[8]  = mk( 7,  7, 1, 0, 0, 0, 0, 0,  0, 1, 7, 0, 5'b11010);
    tbl[9]  = mk( 1,  2, 1, 0, 1, 1, 0, 0,  0, 0, 0, 0, 5'b11110);
    tbl[10] = mk( 4,  9, 1, 1, 0, 1, 1, 1,  4, 0, 0, 0, 5'b00011);
    tbl[11] = mk( 4,  9, 1, 0, 0, 0, 1, 1,  9, 0, 0, 1, 5'b00000);
    tbl[12] = mk( 1,  2, 0, 0, 1, 1, 0, 0,  0, 0, 0, 1, 5'b00000);
    tbl[13] = mk( 6,  0, 0, 0, 0, 0, 0, 1,  6, 0, 0, 0, 5'b11010);
    tbl[14] = mk( 0,  0, 0, 0, 2, 0, 0, 1,  0, 0, 0, 0, 5'b11010);

    clr();
    @(posedge clk);
    #1;
    do_reset();

    for (int i = 0; i < 15; i++) begin
      apply(tbl[i]);
      go();
      chk($sformatf("vec%0d_outs", i), pack_out(), int'(tbl[i].exp));
      tick();
    end
    clr(); go();
    chk("table_stall_cnt", int'(hif.Stall_Count), 5);
    chk("table_flush_cnt", int'(hif.Flush_Count), 1);
    tick();

    // Load-use: one stall then clear
    do_reset();
    load_use(); go();
    chk("lu_pc_write", int'(hif.PC_Write), 0);
    chk("lu_ifid_write", int'(hif.IF_ID_Write), 0);
    chk("lu_idex_flush", int'(hif.ID_EX_Flush), 1);
    tick();
    clr(); go();
    chk("lu_after_pc_write", int'(hif.PC_Write), 1);
    chk("lu_stall_cnt", int'(hif.Stall_Count), 1);
    tick();

    // Load feeding a branch: H2 then H3, then taken flush
    do_reset();
    clr(); hif.ID_Branch = 1; hif.ID_Rs = 5; hif.EX_MemRead = 1; hif.EX_RegWrite = 1; hif.EX_WriteReg = 5;
    go(); chk("ldbr_c1", pack_out(), 5'b00011); tick();
    clr(); hif.ID_Branch = 1; hif.ID_Rs = 5; hif.MEM_MemRead = 1; hif.MEM_WriteReg = 5;
    go(); chk("ldbr_c2", pack_out(), 5'b00011); tick();
    clr(); hif.ID_Branch = 1; hif.ID_Rs = 5; hif.ID_Taken = 1;
    go(); chk("ldbr_c3", pack_out(), 5'b11110); tick();
    clr(); go();
    chk("ldbr_stall_cnt", int'(hif.Stall_Count), 2);
    chk("ldbr_flush_cnt", int'(hif.Flush_Count), 1);
    tick();

    // jr $31 behind addi $31, then the same with $0
    do_reset();
    clr(); hif.ID_PCSrc = 2; hif.ID_Rs = 31; hif.EX_RegWrite = 1; hif.EX_WriteReg = 31;
    go(); chk("jr31", pack_out(), 5'b00011); tick();
    clr(); hif.ID_PCSrc = 2; hif.ID_Rs = 0; hif.EX_RegWrite = 1; hif.EX_WriteReg = 0;
    go(); chk("jr0", pack_out(), 5'b11010); tick();

    // mult at t, mflo waits t+1..t+4, back-to-back issue, countdown through Ext_Stall
    do_reset();
    clr(); hif.ID_MulDiv = 1;
    go(); chk("md_issue_busy", int'(hif.MD_Busy), 0); chk("md_issue_outs", pack_out(), 5'b11010); tick();
    for (int k = 1; k <= 4; k++) begin
      clr(); hif.ID_ReadHiLo = 1; go();
      chk($sformatf("md_busy_t%0d", k), int'(hif.MD_Busy), 1);
      chk($sformatf("md_mflo_stall_t%0d", k), pack_out(), 5'b00011);
      tick();
    end
    clr(); hif.ID_ReadHiLo = 1; go();
    chk("md_busy_t5", int'(hif.MD_Busy), 0);
    chk("md_mflo_adv_t5", pack_out(), 5'b11010);
    tick();
    clr(); hif.ID_MulDiv = 1; go();
    chk("md_b2b_outs", pack_out(), 5'b11010); tick();
    for (int k = 0; k < 4; k++) begin
      clr(); hif.Ext_Stall = (k < 2); go();
      chk($sformatf("md_ext_busy%0d", k), int'(hif.MD_Busy), 1);
      tick();
    end
    clr(); go();
    chk("md_ext_idle", int'(hif.MD_Busy), 0);
    chk("md_stall_cnt", int'(hif.Stall_Count), 4);
    tick();

    // Ext_Stall over a load-use hazard
    do_reset();
    load_use(); hif.Ext_Stall = 1; go();
    chk("ext_outs", pack_out(), 5'b00000); tick();
    load_use(); go();
    chk("ext_cnt_held", int'(hif.Stall_Count), 0);
    chk("ext_resume", pack_out(), 5'b00011); tick();
    clr(); go(); chk("ext_stall_cnt", int'(hif.Stall_Count), 1); tick();

    // Reset in the middle of BUSY with Stall_Count=7
    do_reset();
    clr(); hif.ID_MulDiv = 1; go(); tick();
    for (int k = 0; k < 4; k++) begin clr(); hif.ID_ReadHiLo = 1; go(); tick(); end
    for (int k = 0; k < 3; k++) begin load_use(); go(); tick(); end
    clr(); hif.ID_MulDiv = 1; go(); tick();
    clr(); go();
    chk("mid_busy", int'(hif.MD_Busy), 1);
    chk("mid_stall_cnt", int'(hif.Stall_Count), 7);
    tick();
    do_reset();

    // Counter saturation
    for (int k = 0; k < 20; k++) begin load_use(); go(); tick(); end
    for (int k = 0; k < 20; k++) begin clr(); hif.ID_Taken = 1; go(); tick(); end
    clr(); go();
    chk("sat_stall_cnt", int'(hif.Stall_Count), CMAX);
    chk("sat_flush_cnt", int'(hif.Flush_Count), CMAX);
    tick();

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      reset            = ($urandom_range(0, 79) != 0);
      hif.ID_Rs        = 5'($urandom_range(0, 3));
      hif.ID_Rt        = 5'($urandom_range(0, 3));
      hif.ID_UseRt     = 1'($urandom_range(0, 1));
      hif.ID_Branch    = ($urandom_range(0, 3) == 0);
      hif.ID_PCSrc     = 2'($urandom_range(0, 3));
      hif.ID_Taken     = ($urandom_range(0, 3) == 0);
      hif.ID_MulDiv    = ($urandom_range(0, 5) == 0);
      hif.ID_ReadHiLo  = ($urandom_range(0, 5) == 0);
      hif.EX_MemRead   = ($urandom_range(0, 3) == 0);
      hif.EX_RegWrite  = 1'($urandom_range(0, 1));
      hif.EX_WriteReg  = 5'($urandom_range(0, 3));
      hif.MEM_MemRead  = ($urandom_range(0, 3) == 0);
      hif.MEM_WriteReg = 5'($urandom_range(0, 3));
      hif.Ext_Stall    = ($urandom_range(0, 7) == 0);
      go();
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/hazard_unit.md
Name: hazard_unit

Overview:
- Pipeline hazard controller for the 5-stage MIPS core; it covers the cases that operand forwarding cannot resolve.
- Detects load-use hazards and branch/jr operand-not-ready hazards in ID. It stalls PC and IF/ID and injects bubbles into ID/EX.
- Flushes IF/ID on taken control transfers.
- Tracks a multi-cycle mul/div unit with an internal busy FSM. Exports saturating stall and flush counters for performance monitoring.

Parameters:
MD_LATENCY, 4, busy cycles of the mul/div unit after issue (legal range 1..15)
CNT_W, 32, width of the performance counters

Ports:
clk  in  1  core clock
reset  in  1  synchronous, active-low reset
ID_Rs  in  5  rs field of the instruction in ID
ID_Rt  in  5  rt field of the instruction in ID
ID_UseRt  in  1  ID instruction reads rt as a source
ID_Branch  in  1  conditional branch in ID
ID_PCSrc  in  2  PC source in ID; bit1=1 means jr/jalr (reads rs)
ID_Taken  in  1  ID control transfer resolved taken (branch taken or any jump)
ID_MulDiv  in  1  ID instruction is mult/multu/div/divu
ID_ReadHiLo  in  1  ID instruction is mfhi/mflo
EX_MemRead  in  1  load in EX
EX_RegWrite  in  1  EX writes the register file
EX_WriteReg  in  5  EX destination register
MEM_MemRead  in  1  load in MEM
MEM_WriteReg  in  5  MEM destination register
Ext_Stall  in  1  memory-system freeze request
PC_Write  out  1  PC write enable
IF_ID_Write  out  1  IF/ID write enable
IF_ID_Flush  out  1  clear IF/ID to NOP
ID_EX_Write  out  1  ID/EX write enable
ID_EX_Flush  out  1  load bubble into ID/EX
MD_Busy  out  1  mul/div unit busy (registered state)
Stall_Count  out  CNT_W  hazard stall cycles
Flush_Count  out  CNT_W  IF/ID flush cycles

Behaviour:
- Register 0 never creates a hazard; every compare requires WriteReg != 0.
- Source match: ID_Rs matches WriteReg; or ID_Rt matches WriteReg and ID_UseRt=1.
- Control-in-ID (CTL) = ID_Branch | ID_PCSrc[1]. For a jr, only rs is the control operand; for a branch, both rs and rt are.
- Hazards, combinational on the current inputs:
  - H1 load-use: EX_MemRead and the EX destination matches a source.
  - H2: CTL and EX_RegWrite and EX_WriteReg matches a control operand. This covers both an ALU result and a load in EX.
  - H3: CTL and MEM_MemRead and MEM_WriteReg matches a control operand.
  - H4: MD_Busy and (ID_MulDiv or ID_ReadHiLo).
- HazStall = H1|H2|H3|H4.
- A load feeding a branch therefore stalls exactly 2 cycles (H2, then H3). An ALU op feeding a branch stalls 1 cycle, after which it is forwarded from MEM.
- Outputs, in priority order:
  1. reset=0: PC_Write=1, IF_ID_Write=1, ID_EX_Write=1, both flushes 0.
  2. Ext_Stall=1: PC_Write=0, IF_ID_Write=0, ID_EX_Write=0, both flushes 0. The pipeline is frozen and hazards are ignored.
  3. HazStall=1: PC_Write=0, IF_ID_Write=0, ID_EX_Write=1, ID_EX_Flush=1, IF_ID_Flush=0. ID_Taken is ignored while stalled.
  4. ID_Taken=1: IF_ID_Flush=1; all write enables 1.
  5. Otherwise all write enables 1, both flushes 0.
- Mul/div FSM (states IDLE, BUSY; 4-bit down-counter):
  - Issue = ID_MulDiv & ~HazStall & ~Ext_Stall & reset.
  - IDLE→BUSY on issue; the counter loads MD_LATENCY. MD_Busy=1 from the cycle after issue.
  - In BUSY the counter decrements every cycle, including during Ext_Stall. When the counter is 1, the next state is IDLE. This gives exactly MD_LATENCY busy cycles.
  - While BUSY, a new mul/div is held in ID by H4; it cannot re-issue until IDLE.
  - Back-to-back: issue is possible in the first IDLE cycle.
- Counters:
  - Stall_Count +1 on each cycle with HazStall & ~Ext_Stall.
  - Flush_Count +1 on each cycle with IF_ID_Flush.
  - Both saturate at all-ones and never wrap.
- Reset (reset=0 at a clk edge, including mid-stall or mid-BUSY): FSM→IDLE, counter→0, MD_Busy=0, both counts→0.

Test Plan:
- Load-use: lw $8 in EX (EX_MemRead=1, EX_WriteReg=8); ID add with ID_Rt=8, ID_UseRt=1 → 1 cycle: PC_Write=0, IF_ID_Write=0, ID_EX_Flush=1. Next cycle clear; Stall_Count=1.
- Branch after load: lw $5 then beq $5,$0 → 2 stall cycles (H2 then H3), then ID_Taken=1 gives IF_ID_Flush=1 for 1 cycle; Stall_Count=2, Flush_Count=1.
- jr $31 with EX addi writing $31 → 1 stall cycle. Same EX write to $0 with ID_Rs=0 → no stall.
- MD_LATENCY=4: issue mult at cycle t → MD_Busy=1 for cycles t+1..t+4. mflo in ID at t+1 stalls 4 cycles (t+1..t+4) and advances at t+5.
- Ext_Stall asserted concurrently with a load-use hazard → all write enables 0, ID_EX_Flush=0, Stall_Count unchanged. The hazard stall resumes when Ext_Stall drops.
- reset=0 mid-BUSY and with Stall_Count=7 → next edge: MD_Busy=0, Stall_Count=0, Flush_Count=0; outputs are the reset defaults while reset=0.
